ex_alu_mul: RTL and testbench

// - Execute stage. Consumes the registered ex_* bundle from the ID/EX pipeline register and drives the EX/MEM register and the forwarding paths.
// - Logic, arithmetic and shift ops complete in a single cycle.
// - RV32M multiply ops use a 32-iteration serial shift-add FSM and hold the pipeline with stall_req until the result is ready.

---
 rtl/ex_alu_mul.sv | 336 +++++++++++++++++++++++++++++++++
 tb/tb_ex_alu_mul.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_alu_mul.sv
// ex_alu_mul -- execute stage ALU with serial RV32M multiply.
// Logic, arithmetic and shift ops are combinational from the ID/EX bundle.
// MUL/MULH/MULHSU/MULHU run on a 32-iteration shift-add FSM
// (IDLE -> BUSY -> DONE) and hold the pipeline through stall_req.
// Optional feature macro: EX_DIV_EN adds DIV/DIVU/REM/REMU as serial
// restoring division on the same FSM. Without it those op codes decode
// as NOP class and no divider hardware exists.
module ex_alu_mul #(
  parameter int XLEN      = 32,  // only 32 is supported
  parameter int MUL_ITERS = 32   // must equal XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [7:0]      ex_aluop,
  input  logic [2:0]      ex_alusel,
  input  logic [XLEN-1:0] ex_r1_data,
  input  logic [XLEN-1:0] ex_r2_data,
  input  logic            ex_w_enable,
  input  logic [4:0]      ex_w_addr,
  output logic            ex_w_enable_o,
  output logic [4:0]      ex_w_addr_o,
  output logic [XLEN-1:0] ex_w_data_o,
  output logic            stall_req
);

  // Result class encodings (ex_alusel)
  localparam logic [2:0] SEL_NOP    = 3'd0;
  localparam logic [2:0] SEL_LOGIC  = 3'd1;
  localparam logic [2:0] SEL_ARITH  = 3'd2;
  localparam logic [2:0] SEL_SHIFT  = 3'd3;
  localparam logic [2:0] SEL_MULDIV = 3'd4;

  // Op code encodings (ex_aluop)
  localparam logic [7:0] OP_AND    = 8'h01;
  localparam logic [7:0] OP_OR     = 8'h02;
  localparam logic [7:0] OP_XOR    = 8'h03;
  localparam logic [7:0] OP_ADD    = 8'h10;
  localparam logic [7:0] OP_SUB    = 8'h11;
  localparam logic [7:0] OP_SLT    = 8'h12;
  localparam logic [7:0] OP_SLTU   = 8'h13;
  localparam logic [7:0] OP_SLL    = 8'h20;
  localparam logic [7:0] OP_SRL    = 8'h21;
  localparam logic [7:0] OP_SRA    = 8'h22;
  localparam logic [7:0] OP_MUL    = 8'h30;
  localparam logic [7:0] OP_MULH   = 8'h31;
  localparam logic [7:0] OP_MULHSU = 8'h32;
  localparam logic [7:0] OP_MULHU  = 8'h33;
`ifdef EX_DIV_EN
  localparam logic [7:0] OP_DIV    = 8'h34;
  localparam logic [7:0] OP_DIVU   = 8'h35;
  localparam logic [7:0] OP_REM    = 8'h36;
  localparam logic [7:0] OP_REMU   = 8'h37;
`endif

  // FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int CNT_W = $clog2(MUL_ITERS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITERS - 1);

  // Decode outputs
  logic [XLEN-1:0] alu_res;
  logic            alu_valid;
  logic            md_valid;
  logic            md_sign_a;
  logic            md_sign_b;
  logic            md_take_hi;

  // Operand conditioning
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;

  // Sequential state
  logic [1:0]       state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [XLEN-1:0]  hi_q,      hi_d;
  logic [XLEN-1:0]  lo_q,      lo_d;
  logic [XLEN-1:0]  opb_q,     opb_d;
  logic             neg_q,     neg_d;
  logic             take_hi_q, take_hi_d;

  // Iteration datapath
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   mul_hi;
  logic [XLEN-1:0]   mul_lo;
  logic [2*XLEN-1:0] prod_raw;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   md_res;

`ifdef EX_DIV_EN
  logic            md_is_div;
  logic            is_div_q,     is_div_d;
  logic            rem_neg_q,    rem_neg_d;
  logic            div_zero_q,   div_zero_d;
  logic [XLEN-1:0] dividend_q,   dividend_d;
  logic [XLEN:0]   rem_sh;
  logic            rem_ge;
  logic [XLEN-1:0] rem_sub;
  logic [XLEN-1:0] div_hi;
  logic [XLEN-1:0] div_lo;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
`endif

  // Decode the (class, op) pair; unknown ops inside a class fall to NOP.
  always_comb begin
    alu_res    = '0;
    alu_valid  = 1'b0;
    md_valid   = 1'b0;
    md_sign_a  = 1'b0;
    md_sign_b  = 1'b0;
    md_take_hi = 1'b0;
`ifdef EX_DIV_EN
    md_is_div  = 1'b0;
`endif
    case (ex_alusel)
      SEL_LOGIC: begin
        case (ex_aluop)
          OP_AND:  begin alu_res = ex_r1_data & ex_r2_data; alu_valid = 1'b1; end
          OP_OR:   begin alu_res = ex_r1_data | ex_r2_data; alu_valid = 1'b1; end
          OP_XOR:  begin alu_res = ex_r1_data ^ ex_r2_data; alu_valid = 1'b1; end
          default: ;
        endcase
      end
      SEL_ARITH: begin
        case (ex_aluop)
          OP_ADD:  begin alu_res = ex_r1_data + ex_r2_data; alu_valid = 1'b1; end
          OP_SUB:  begin alu_res = ex_r1_data - ex_r2_data; alu_valid = 1'b1; end
          OP_SLT: begin
            alu_res   = {{(XLEN-1){1'b0}}, ($signed(ex_r1_data) < $signed(ex_r2_data))};
            alu_valid = 1'b1;
          end
          OP_SLTU: begin
            alu_res   = {{(XLEN-1){1'b0}}, (ex_r1_data < ex_r2_data)};
            alu_valid = 1'b1;
          end
          default: ;
        endcase
      end
      SEL_SHIFT: begin
        case (ex_aluop)
          OP_SLL:  begin alu_res = ex_r1_data << ex_r2_data[4:0]; alu_valid = 1'b1; end
          OP_SRL:  begin alu_res = ex_r1_data >> ex_r2_data[4:0]; alu_valid = 1'b1; end
          OP_SRA: begin
            alu_res   = $signed(ex_r1_data) >>> ex_r2_data[4:0];
            alu_valid = 1'b1;
          end
          default: ;
        endcase
      end
      SEL_MULDIV: begin
        case (ex_aluop)
          OP_MUL:    md_valid = 1'b1;
          OP_MULH:   begin md_valid = 1'b1; md_sign_a = 1'b1; md_sign_b = 1'b1; md_take_hi = 1'b1; end
          OP_MULHSU: begin md_valid = 1'b1; md_sign_a = 1'b1; md_take_hi = 1'b1; end
          OP_MULHU:  begin md_valid = 1'b1; md_take_hi = 1'b1; end
`ifdef EX_DIV_EN
          OP_DIV:    begin md_valid = 1'b1; md_is_div = 1'b1; md_sign_a = 1'b1; md_sign_b = 1'b1; end
          OP_DIVU:   begin md_valid = 1'b1; md_is_div = 1'b1; end
          OP_REM: begin
            md_valid = 1'b1; md_is_div = 1'b1; md_sign_a = 1'b1; md_sign_b = 1'b1; md_take_hi = 1'b1;
          end
          OP_REMU:   begin md_valid = 1'b1; md_is_div = 1'b1; md_take_hi = 1'b1; end
`endif
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Convert signed operands to magnitudes; the sign is restored at the end.
  always_comb begin
    a_neg = md_sign_a & ex_r1_data[XLEN-1];
    b_neg = md_sign_b & ex_r2_data[XLEN-1];
    a_mag = a_neg ? (~ex_r1_data + 1'b1) : ex_r1_data;
    b_mag = b_neg ? (~ex_r2_data + 1'b1) : ex_r2_data;
  end

  // One shift-add (and, when built, one restoring-divide) step per BUSY cycle.
  // Multiply keeps {hi,lo} as the running product with the multiplier
  // shifting out of lo; divide keeps the remainder in hi and the quotient in lo.
  always_comb begin
    mul_sum = {1'b0, hi_q} + ({1'b0, opb_q} & {(XLEN+1){lo_q[0]}});
    mul_hi  = mul_sum[XLEN:1];
    mul_lo  = {mul_sum[0], lo_q[XLEN-1:1]};
`ifdef EX_DIV_EN
    rem_sh  = {hi_q, lo_q[XLEN-1]};
    rem_ge  = (rem_sh >= {1'b0, opb_q});
    rem_sub = rem_sh[XLEN-1:0] - opb_q;
    div_hi  = rem_ge ? rem_sub : rem_sh[XLEN-1:0];
    div_lo  = {lo_q[XLEN-2:0], rem_ge};
`endif
  end

  // Final sign fix-up and word select for the DONE cycle.
  always_comb begin
    prod_raw = {hi_q, lo_q};
    prod_fix = neg_q ? (~prod_raw + 1'b1) : prod_raw;
    md_res   = take_hi_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
`ifdef EX_DIV_EN
    quo_fix  = neg_q     ? (~lo_q + 1'b1) : lo_q;
    rem_fix  = rem_neg_q ? (~hi_q + 1'b1) : hi_q;
    if (div_zero_q) begin
      quo_fix = '1;
      rem_fix = dividend_q;
    end
    if (is_div_q) begin
      md_res = take_hi_q ? rem_fix : quo_fix;
    end
`endif
  end

  // FSM next state: latch operands in IDLE, iterate in BUSY, release in DONE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opb_d     = opb_q;
    neg_d     = neg_q;
    take_hi_d = take_hi_q;
`ifdef EX_DIV_EN
    is_div_d   = is_div_q;
    rem_neg_d  = rem_neg_q;
    div_zero_d = div_zero_q;
    dividend_d = dividend_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (md_valid && !flush) begin
          state_d   = ST_BUSY;
          cnt_d     = '0;
          hi_d      = '0;
          lo_d      = a_mag;
          opb_d     = b_mag;
          neg_d     = a_neg ^ b_neg;
          take_hi_d = md_take_hi;
`ifdef EX_DIV_EN
          is_div_d   = md_is_div;
          rem_neg_d  = a_neg;
          div_zero_d = (ex_r2_data == '0);
          dividend_d = ex_r1_data;
`endif
        end
      end
      ST_BUSY: begin
`ifdef EX_DIV_EN
        hi_d = is_div_q ? div_hi : mul_hi;
        lo_d = is_div_q ? div_lo : mul_lo;
`else
        hi_d = mul_hi;
        lo_d = mul_lo;
`endif
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;  // instruction advances on this edge
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  // Output mux: reset forces zeros; stalls hide partial results from forwarding.
  always_comb begin
    ex_w_enable_o = 1'b0;
    ex_w_addr_o   = ex_w_addr;
    ex_w_data_o   = '0;
    stall_req     = 1'b0;
    if (rst) begin
      ex_w_addr_o = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (md_valid) begin
            stall_req = !flush;
          end else if (alu_valid) begin
            ex_w_data_o   = alu_res;
            ex_w_enable_o = ex_w_enable & !flush;
          end
        end
        ST_BUSY: stall_req = 1'b1;
        ST_DONE: begin
          ex_w_data_o   = md_res;
          ex_w_enable_o = ex_w_enable & !flush;
        end
        default: ;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opb_q     <= '0;
      neg_q     <= 1'b0;
      take_hi_q <= 1'b0;
`ifdef EX_DIV_EN
      is_div_q   <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      dividend_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opb_q     <= opb_d;
      neg_q     <= neg_d;
      take_hi_q <= take_hi_d;
`ifdef EX_DIV_EN
      is_div_q   <= is_div_d;
      rem_neg_q  <= rem_neg_d;
      div_zero_q <= div_zero_d;
      dividend_q <= dividend_d;
`endif
    end
  end

endmodule

// File: tb/tb_ex_alu_mul.sv
// tb_ex_alu_mul -- scoreboard bench for ex_alu_mul.
// Expected results are queued when an op is driven and popped when the DUT
// presents its result (same cycle for single-cycle ops, DONE for mul/div).
module tb_ex_alu_mul;

  localparam logic [2:0] SEL_NOP    = 3'd0;
  localparam logic [2:0] SEL_LOGIC  = 3'd1;
  localparam logic [2:0] SEL_ARITH  = 3'd2;
  localparam logic [2:0] SEL_SHIFT  = 3'd3;
  localparam logic [2:0] SEL_MULDIV = 3'd4;

  localparam logic [7:0] OP_AND    = 8'h01;
  localparam logic [7:0] OP_OR     = 8'h02;
  localparam logic [7:0] OP_XOR    = 8'h03;
  localparam logic [7:0] OP_ADD    = 8'h10;
  localparam logic [7:0] OP_SUB    = 8'h11;
  localparam logic [7:0] OP_SLT    = 8'h12;
  localparam logic [7:0] OP_SLTU   = 8'h13;
  localparam logic [7:0] OP_SLL    = 8'h20;
  localparam logic [7:0] OP_SRL    = 8'h21;
  localparam logic [7:0] OP_SRA    = 8'h22;
  localparam logic [7:0] OP_MUL    = 8'h30;
  localparam logic [7:0] OP_MULH   = 8'h31;
  localparam logic [7:0] OP_MULHSU = 8'h32;
  localparam logic [7:0] OP_MULHU  = 8'h33;
  localparam logic [7:0] OP_DIV    = 8'h34;
  localparam logic [7:0] OP_DIVU   = 8'h35;
  localparam logic [7:0] OP_REM    = 8'h36;
  localparam logic [7:0] OP_REMU   = 8'h37;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [7:0]  ex_aluop;
  logic [2:0]  ex_alusel;
  logic [31:0] ex_r1_data;
  logic [31:0] ex_r2_data;
  logic        ex_w_enable;
  logic [4:0]  ex_w_addr;
  logic        ex_w_enable_o;
  logic [4:0]  ex_w_addr_o;
  logic [31:0] ex_w_data_o;
  logic        stall_req;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic        we;
    logic [4:0]  addr;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  ex_alu_mul dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .ex_aluop     (ex_aluop),
    .ex_alusel    (ex_alusel),
    .ex_r1_data   (ex_r1_data),
    .ex_r2_data   (ex_r2_data),
    .ex_w_enable  (ex_w_enable),
    .ex_w_addr    (ex_w_addr),
    .ex_w_enable_o(ex_w_enable_o),
    .ex_w_addr_o  (ex_w_addr_o),
    .ex_w_data_o  (ex_w_data_o),
    .stall_req    (stall_req)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Reference result for RV32M ops, built from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_md(input logic [7:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      OP_MUL:    begin p = ua * ub; return p[31:0];  end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * ub; return p[63:32]; end
      OP_MULHU:  begin p = ua * ub; return p[63:32]; end
      OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      OP_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      OP_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      OP_REMU: return (b == 32'd0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic we, input logic [4:0] addr);
    @(posedge clk);
    #1;
    flush       = 1'b0;
    ex_aluop    = op;
    ex_alusel   = sel;
    ex_r1_data  = a;
    ex_r2_data  = b;
    ex_w_enable = we;
    ex_w_addr   = addr;
  endtask

  task automatic drive_nop();
    drive(8'h00, SEL_NOP, 32'd0, 32'd0, 1'b0, 5'd0);
  endtask

  // Single-cycle op: result is expected in the same cycle, no stall.
  task automatic run_single(input string tag, input logic [7:0] op, input logic [2:0] sel,
                            input logic [31:0] a, input logic [31:0] b, input logic we,
                            input logic [4:0] addr, input logic [31:0] exp_data,
                            input logic exp_we);
    exp_t e;
    e.data = exp_data;
    e.we   = exp_we;
    e.addr = addr;
    exp_q.push_back(e);
    drive(op, sel, a, b, we, addr);
    @(negedge clk);
    e = exp_q.pop_front();
    check_val({tag, ".data"},  ex_w_data_o, e.data);
    check_val({tag, ".we"},    {31'd0, ex_w_enable_o}, {31'd0, e.we});
    check_val({tag, ".addr"},  {27'd0, ex_w_addr_o}, {27'd0, e.addr});
    check_val({tag, ".stall"}, {31'd0, stall_req}, 32'd0);
    $display("%-12s a=%08h b=%08h -> data=%08h we=%0d", tag, a, b, ex_w_data_o, ex_w_enable_o);
  endtask

  // Multi-cycle op: count stall cycles, then compare the DONE-cycle result.
  task automatic run_md(input string tag, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic we, input logic [4:0] addr);
    exp_t e;
    int   n_stall;
    logic bad_fwd;
    e.data = ref_md(op, a, b);
    e.we   = we;
    e.addr = addr;
    exp_q.push_back(e);
    drive(op, SEL_MULDIV, a, b, we, addr);
    n_stall = 0;
    bad_fwd = 1'b0;
    @(negedge clk);
    while (stall_req === 1'b1 && n_stall < 100) begin
      n_stall++;
      if (ex_w_enable_o !== 1'b0 || ex_w_addr_o !== addr) bad_fwd = 1'b1;
      @(negedge clk);
    end
    e = exp_q.pop_front();
    check_val({tag, ".stalls"}, n_stall, 32'd33);
    check_val({tag, ".stallwe"}, {31'd0, bad_fwd}, 32'd0);
    check_val({tag, ".data"}, ex_w_data_o, e.data);
    check_val({tag, ".we"}, {31'd0, ex_w_enable_o}, {31'd0, e.we});
    $display("%-12s a=%08h b=%08h -> data=%08h we=%0d stalls=%0d", tag, a, b, ex_w_data_o,
             ex_w_enable_o, n_stall);
  endtask

  // Watch a window of cycles and flag any write-back that appears.
  task automatic watch_no_write(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (ex_w_enable_o !== 1'b0 || stall_req !== 1'b0) seen = 1'b1;
    end
    check_val(tag, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got=running expected=done");
    $fatal(1);
  end

  initial begin
    logic [7:0] mul_ops [4];
    logic [7:0] div_ops [4];
    logic [31:0] ra, rb;
    mul_ops = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    div_ops = '{OP_DIV, OP_DIVU, OP_REM, OP_REMU};

    // Reset with live requests on the bundle: outputs must stay at zero.
    rst         = 1'b1;
    flush       = 1'b0;
    ex_aluop    = OP_MUL;
    ex_alusel   = SEL_MULDIV;
    ex_r1_data  = 32'd3;
    ex_r2_data  = 32'd4;
    ex_w_enable = 1'b1;
    ex_w_addr   = 5'd7;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst.we",    {31'd0, ex_w_enable_o}, 32'd0);
    check_val("rst.addr",  {27'd0, ex_w_addr_o}, 32'd0);
    check_val("rst.data",  ex_w_data_o, 32'd0);
    check_val("rst.stall", {31'd0, stall_req}, 32'd0);
    $display("reset        we=%0d addr=%0d data=%08h stall=%0d", ex_w_enable_o, ex_w_addr_o,
             ex_w_data_o, stall_req);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    ex_alusel = SEL_NOP;

    // Single-cycle ops
    run_single("add_ovf", OP_ADD,  SEL_ARITH, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 5'd5, 32'h8000_0000, 1'b1);
    run_single("sub",     OP_SUB,  SEL_ARITH, 32'h0000_0000, 32'h0000_0001, 1'b1, 5'd3, 32'hFFFF_FFFF, 1'b1);
    run_single("and",     OP_AND,  SEL_LOGIC, 32'hF0F0_F0F0, 32'h3C3C_3C3C, 1'b1, 5'd1, 32'h3030_3030, 1'b1);
    run_single("or",      OP_OR,   SEL_LOGIC, 32'hF0F0_F0F0, 32'h0F0F_0000, 1'b1, 5'd2, 32'hFFFF_F0F0, 1'b1);
    run_single("xor",     OP_XOR,  SEL_LOGIC, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b1, 5'd4, 32'hF0F0_0F0F, 1'b1);
    run_single("sll",     OP_SLL,  SEL_SHIFT, 32'h0000_0001, 32'hFFFF_FFE1, 1'b1, 5'd6, 32'h0000_0002, 1'b1);
    run_single("srl",     OP_SRL,  SEL_SHIFT, 32'h8000_0000, 32'h0000_0024, 1'b1, 5'd8, 32'h0800_0000, 1'b1);
    run_single("sra",     OP_SRA,  SEL_SHIFT, 32'h8000_0000, 32'h0000_0024, 1'b1, 5'd9, 32'hF800_0000, 1'b1);
    run_single("slt",     OP_SLT,  SEL_ARITH, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 5'd10, 32'h0000_0001, 1'b1);
    run_single("sltu",    OP_SLTU, SEL_ARITH, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 5'd11, 32'h0000_0000, 1'b1);
    run_single("slt_pos", OP_SLT,  SEL_ARITH, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 5'd12, 32'h0000_0000, 1'b1);
    run_single("add_nowe", OP_ADD, SEL_ARITH, 32'h0000_0001, 32'h0000_0002, 1'b0, 5'd13, 32'h0000_0003, 1'b0);
    run_single("nop",     OP_ADD,  SEL_NOP,   32'h1234_5678, 32'h1111_1111, 1'b1, 5'd14, 32'h0000_0000, 1'b0);
    run_single("undef_op", 8'h7F,  SEL_LOGIC, 32'h1234_5678, 32'h1111_1111, 1'b1, 5'd15, 32'h0000_0000, 1'b0);

    // Multiply ops, including two back-to-back MULHU
    run_md("mulh",    OP_MULH,   32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 5'd16);
    run_md("mul",     OP_MUL,    32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 5'd17);
    run_md("mulhu_a", OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd18);
    run_md("mulhu_b", OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd19);
    run_md("mulhsu",  OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 5'd20);
    run_md("mulh_mn", OP_MULH,   32'h8000_0000, 32'h8000_0000, 1'b1, 5'd21);
    run_md("mul_nowe", OP_MUL,   32'h0000_0007, 32'h0000_0006, 1'b0, 5'd22);
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_md($sformatf("mrand%0d", i), mul_ops[$urandom_range(0, 3)], ra, rb, 1'b1, 5'(i + 1));
    end

`ifdef EX_DIV_EN
    run_md("div_by0",  OP_DIV,  32'h0000_0007, 32'h0000_0000, 1'b1, 5'd23);
    run_md("rem_neg",  OP_REM,  32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 5'd24);
    run_md("div_ovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 5'd25);
    run_md("rem_ovf",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 5'd26);
    run_md("rem_by0",  OP_REM,  32'hFFFF_FFF9, 32'h0000_0000, 1'b1, 5'd27);
    run_md("divu",     OP_DIVU, 32'h0000_0064, 32'h0000_0007, 1'b1, 5'd28);
    run_md("remu",     OP_REMU, 32'h0000_0064, 32'h0000_0007, 1'b1, 5'd29);
    run_md("div_neg",  OP_DIV,  32'hFFFF_FF9C, 32'h0000_0007, 1'b1, 5'd30);
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom_range(1, 32'h0001_0000);
      run_md($sformatf("drand%0d", i), div_ops[$urandom_range(0, 3)], ra, rb, 1'b1, 5'(i + 1));
    end
`else
    run_single("div_off", OP_DIV,  SEL_MULDIV, 32'h0000_0007, 32'h0000_0000, 1'b1, 5'd23, 32'h0, 1'b0);
    run_single("remu_off", OP_REMU, SEL_MULDIV, 32'h0000_0064, 32'h0000_0007, 1'b1, 5'd24, 32'h0, 1'b0);
`endif

    // Flush on BUSY cycle 10: back to IDLE, no write-back afterwards.
    drive(OP_MULH, SEL_MULDIV, 32'h0000_0003, 32'h0000_0005, 1'b1, 5'd6);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check_val("flush.cyc_we", {31'd0, ex_w_enable_o}, 32'd0);
    @(posedge clk);
    #1;
    flush     = 1'b0;
    ex_alusel = SEL_NOP;
    @(negedge clk);
    check_val("flush.stall", {31'd0, stall_req}, 32'd0);
    check_val("flush.we",    {31'd0, ex_w_enable_o}, 32'd0);
    watch_no_write("flush.nowb", 40);
    $display("flush_busy   stall=%0d we=%0d", stall_req, ex_w_enable_o);

    // Flush together with an op arriving in IDLE suppresses the start.
    drive(OP_MUL, SEL_MULDIV, 32'h0000_0003, 32'h0000_0005, 1'b1, 5'd7);
    flush = 1'b1;
    @(negedge clk);
    check_val("flush_idle.stall", {31'd0, stall_req}, 32'd0);
    check_val("flush_idle.we",    {31'd0, ex_w_enable_o}, 32'd0);
    drive_nop();
    watch_no_write("flush_idle.nowb", 40);
    $display("flush_idle   stall=%0d we=%0d", stall_req, ex_w_enable_o);

    // Reset in the middle of BUSY on a second op.
    drive(OP_MULHU, SEL_MULDIV, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd8);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_busy.stall", {31'd0, stall_req}, 32'd0);
    check_val("rst_busy.data",  ex_w_data_o, 32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    ex_alusel = SEL_NOP;
    @(negedge clk);
    check_val("rst_after.stall", {31'd0, stall_req}, 32'd0);
    check_val("rst_after.we",    {31'd0, ex_w_enable_o}, 32'd0);
    watch_no_write("rst_after.nowb", 40);
    $display("rst_busy     stall=%0d we=%0d", stall_req, ex_w_enable_o);

    // Normal operation resumes after both aborts.
    run_md("mul_after", OP_MUL, 32'h0001_2345, 32'h0000_6789, 1'b1, 5'd31);
    check_val("scoreboard.empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
